// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-port memory between the CPU and the
// program loader/debug port. Each access runs IDLE -> ISSUE -> WAIT -> DONE.
// The CPU has fixed priority. A starvation counter forces a loader grant after
// STARVE_LIMIT consecutive CPU grants made while the loader was waiting.
module mem_port_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    // CPU side
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    // Loader side
    input  logic          ldr_req_i,
    input  logic          ldr_we_i,
    input  logic [AW-1:0] ldr_addr_i,
    input  logic [DW-1:0] ldr_wdata_i,
    output logic          ldr_ack_o,
    output logic [DW-1:0] ldr_rdata_o,
    output logic          ldr_stall_o,
    // Memory pins
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_din_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_dout_i,
    // Status
    output logic          busy_o,
    output logic          grant_ldr_o
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    // WAIT lasts MEM_LAT cycles; the counter runs from MEM_LAT-1 down to 0.
    localparam logic [2:0] WaitInit    = 3'(MEM_LAT - 1);
    localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

    state_e        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          we_lat_q, we_lat_d;
    logic          grant_ldr_q, grant_ldr_d;
    logic [2:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]    starve_q, starve_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          ldr_win;

    // Next-state logic: arbitration in IDLE, access sequencing elsewhere.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        we_lat_d    = we_lat_q;
        grant_ldr_d = grant_ldr_q;
        wait_cnt_d  = wait_cnt_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        ldr_win     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req_i || ldr_req_i) begin
                    ldr_win     = ldr_req_i && (!cpu_req_i || (starve_q == StarveLimit));
                    grant_ldr_d = ldr_win;
                    mem_addr_d  = ldr_win ? ldr_addr_i : cpu_addr_i;
                    mem_din_d   = ldr_win ? ldr_wdata_i : cpu_wdata_i;
                    mem_we_d    = ldr_win ? ldr_we_i : cpu_we_i;
                    we_lat_d    = ldr_win ? ldr_we_i : cpu_we_i;
                    // Only a CPU grant that leaves the loader waiting counts.
                    if (ldr_win || !ldr_req_i) begin
                        starve_d = 8'd0;
                    end else if (starve_q != 8'hFF) begin
                        starve_d = starve_q + 8'd1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = WaitInit;
                state_d    = StWait;
            end
            StWait: begin
                if (wait_cnt_q == 3'd0) begin
                    if (!we_lat_q) begin
                        if (grant_ldr_q) begin
                            ldr_rdata_d = mem_dout_i;
                        end else begin
                            cpu_rdata_d = mem_dout_i;
                        end
                    end
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any access silently.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            we_lat_q    <= 1'b0;
            grant_ldr_q <= 1'b0;
            wait_cnt_q  <= 3'd0;
            starve_q    <= 8'd0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            we_lat_q    <= we_lat_d;
            grant_ldr_q <= grant_ldr_d;
            wait_cnt_q  <= wait_cnt_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    // Outputs: the ack goes to the current owner during DONE only.
    always_comb begin
        cpu_ack_o   = (state_q == StDone) && !grant_ldr_q;
        ldr_ack_o   = (state_q == StDone) && grant_ldr_q;
        cpu_stall_o = cpu_req_i && !cpu_ack_o;
        ldr_stall_o = ldr_req_i && !ldr_ack_o;
        cpu_rdata_o = cpu_rdata_q;
        ldr_rdata_o = ldr_rdata_q;
        mem_addr_o  = mem_addr_q;
        mem_din_o   = mem_din_q;
        mem_we_o    = mem_we_q;
        busy_o      = (state_q != StIdle);
        grant_ldr_o = grant_ldr_q;
    end

endmodule
